// File: rtl/aes128_round_key_gen_pkg.sv
// Shared AES constants: round count, FSM state encoding and the key-schedule Rcon table.
package aes_pkg;

    localparam int          AES_NR     = 10;
    localparam logic [3:0]  LAST_ROUND = 4'(AES_NR);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Entry i is Rcon[i+1]; a fixed table, no GF doubling in hardware.
    localparam logic [AES_NR-1:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Rcon used to step from the key of the given round to the next one; 0 past the last round.
    function automatic logic [7:0] rcon_next(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < AES_NR; i++) begin
            if (round == 4'(i)) begin
                r = RCON[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_round_key_gen_if.sv
// Load and round-key streaming bundle between the key-schedule engine and its user.
interface aes128_round_key_gen_if;

    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         done;

    modport master (
        output key_in, key_load, rk_ready,
        input  busy, rk_out, rk_round, rk_valid, done
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output busy, rk_out, rk_round, rk_valid, done
    );

endinterface

// File: rtl/aes128_round_key_gen_sbox.sv
// Forward AES S-box, purely combinational; shared with the SubBytes stage, so no local dependencies.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes128_round_key_gen.sv
// Iterative AES-128 key expansion: streams round keys 0..10 over a valid/ready handshake,
// computing each next key on the fly from a single 128-bit key register.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no key presented; a key_load captures key_in as round 0
// ST_RUN  | rk_out/rk_round valid; each handshake advances one round, last one returns to idle
module aes128_round_key_gen
    import aes_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    aes128_round_key_gen_if.slave        rk_if
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w3[8*i +: 8]),
            .out_o (sub_w3[8*i +: 8])
        );
    end

    assign t_word   = sub_w3 ^ {rcon_next(round_q), 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // rk_valid is the RUN state itself, so rk_ready alone decides the handshake there.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rk_if.key_load) begin
                    key_d   = rk_if.key_in;
                    round_d = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rk_if.rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rk_if.busy     = (state_q == ST_RUN);
    assign rk_if.rk_valid = (state_q == ST_RUN);
    assign rk_if.rk_out   = key_q;
    assign rk_if.rk_round = round_q;
    assign rk_if.done     = done_q;

endmodule

// File: tb/tb_aes128_round_key_gen.sv
// Self-checking bench for aes128_round_key_gen: known-answer key schedules plus handshake corner cases.
module tb_aes128_round_key_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes128_round_key_gen_if u_if ();

    aes128_round_key_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rk_if (u_if)
    );

    typedef struct packed {
        logic [127:0]        key;
        logic [10:0][127:0]  rk;
        logic [10:0]         known;
    } vec_t;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        bit           known;
    } exp_t;

    vec_t         vecs [2];
    exp_t         exp_q [$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           prev_stall;
    bit           exp_done;
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    int           n_steps;
    int           k;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
            return;
        end
        if (exp_done || u_if.done) begin
            chk("done_pulse", 128'(u_if.done), 128'(exp_done));
            if (exp_done) chk("done_cycle_idle", 128'({u_if.rk_valid, u_if.busy}), 128'(0));
        end
        exp_done = 1'b0;
        if (prev_stall) begin
            chk("hold_key", u_if.rk_out, prev_out);
            chk("hold_valid_round", 128'({u_if.rk_valid, u_if.rk_round}), 128'({1'b1, prev_round}));
        end
        prev_stall = 1'b0;
        if (u_if.rk_valid && u_if.rk_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_key: got round %0d, expected no key pending", u_if.rk_round);
            end else begin
                e = exp_q.pop_front();
                chk("round_index", 128'(u_if.rk_round), 128'(e.round));
                if (e.known) chk($sformatf("round_key_%0d", e.round), u_if.rk_out, e.key);
                if (e.round == 4'd10) exp_done = 1'b1;
            end
        end else if (u_if.rk_valid) begin
            prev_stall = 1'b1;
            prev_out   = u_if.rk_out;
            prev_round = u_if.rk_round;
        end
    endtask

    // Inputs change on the falling edge; outputs are checked right after.
    task automatic step(input bit rdy);
        @(negedge clk);
        u_if.rk_ready = rdy;
        monitor();
    endtask

    task automatic load(input vec_t v, input bit rdy);
        for (int r = 0; r < 11; r++) begin
            exp_q.push_back('{round: 4'(r), key: v.rk[r], known: v.known[r]});
        end
        u_if.key_in   = v.key;
        u_if.key_load = 1'b1;
        step(rdy);
        u_if.key_load = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd, output int steps);
        steps = 0;
        while (!u_if.done && steps < 400) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            steps++;
        end
        if (!u_if.done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", steps);
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        k = 0;
        while (!(u_if.rk_valid && u_if.rk_round == r) && k < 50) begin
            step(1'b1);
            k++;
        end
        chk("reach_round", 128'(u_if.rk_round), 128'(r));
    endtask

    initial begin
        vecs[0].key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[0].known = 11'h7ff;
        vecs[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        vecs[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        vecs[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        vecs[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        vecs[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        vecs[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        vecs[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        vecs[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        vecs[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        vecs[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[1]        = '0;
        vecs[1].known  = 11'b100_0000_0011;
        vecs[1].rk[1]  = 128'h62636363626363636263636362636363;
        vecs[1].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n         = 1'b0;
        u_if.key_in   = '0;
        u_if.key_load = 1'b0;
        u_if.rk_ready = 1'b0;
        prev_stall    = 1'b0;
        exp_done      = 1'b0;
        #1;
        chk("reset_ctrl", 128'({u_if.busy, u_if.rk_valid, u_if.done, u_if.rk_round}), 128'(0));
        chk("reset_key", u_if.rk_out, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        chk("idle_after_reset", 128'({u_if.busy, u_if.rk_valid}), 128'(0));

        // Known-answer schedules with rk_ready held high: 11 keys back to back, done on edge N+11.
        for (int i = 0; i < 2; i++) begin
            load(vecs[i], 1'b1);
            run_to_done(1'b0, n_steps);
            chk($sformatf("latency_vec%0d", i), 128'(n_steps), 128'(11));
            chk($sformatf("drained_vec%0d", i), 128'(exp_q.size()), 128'(0));
            step(1'b1);
            chk($sformatf("done_width_vec%0d", i), 128'(u_if.done), 128'(0));
        end

        // Random backpressure.
        load(vecs[0], 1'b1);
        run_to_done(1'b1, n_steps);
        chk("drained_random_ready", 128'(exp_q.size()), 128'(0));
        step(1'b1);

        // A load during RUN is ignored.
        load(vecs[0], 1'b1);
        wait_round(4'd4);
        u_if.key_in   = 128'h000102030405060708090a0b0c0d0e0f;
        u_if.key_load = 1'b1;
        step(1'b1);
        u_if.key_load = 1'b0;
        run_to_done(1'b0, n_steps);
        chk("drained_ignored_load", 128'(exp_q.size()), 128'(0));
        step(1'b1);

        // Asynchronous reset mid-sequence, then a clean restart.
        load(vecs[0], 1'b1);
        wait_round(4'd6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_ctrl", 128'({u_if.busy, u_if.rk_valid, u_if.done, u_if.rk_round}), 128'(0));
        chk("midrun_reset_key", u_if.rk_out, 128'h0);
        exp_q.delete();
        prev_stall = 1'b0;
        exp_done   = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1);
        load(vecs[0], 1'b1);
        run_to_done(1'b0, n_steps);
        chk("drained_after_reset", 128'(exp_q.size()), 128'(0));

        // Load in the done cycle: the next run starts immediately.
        step(1'b1);
        load(vecs[0], 1'b1);
        run_to_done(1'b0, n_steps);
        load(vecs[1], 1'b1);
        chk("b2b_start", 128'({u_if.rk_valid, u_if.rk_round}), 128'({1'b1, 4'd0}));
        run_to_done(1'b0, n_steps);
        chk("b2b_latency", 128'(n_steps), 128'(11));
        chk("drained_b2b", 128'(exp_q.size()), 128'(0));
        step(1'b1);
        step(1'b1);
        chk("final_idle", 128'({u_if.busy, u_if.rk_valid, u_if.done}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
